// File: rtl/datapath_seq_pkg.sv
// Shared definitions for the datapath microprogram sequencer.
// Holds the instruction type codes, ALU codes, FSM state encoding and field offsets.
// No logic lives here. Nothing in this file has latency or backpressure.
package datapath_seq_pkg;

  // Instruction type field [15:14]
  typedef enum logic [1:0] {
    T_OP   = 2'b00,
    T_BRZ  = 2'b01,
    T_HALT = 2'b10,
    T_JMP  = 2'b11
  } instr_type_e;

  // ALU codes are passed through to the datapath untouched
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Instruction word layout
  localparam int INSTR_W  = 16;
  localparam int TYPE_LSB = 14;  // [15:14]
  localparam int ALU_LSB  = 11;  // [13:11]
  localparam int A1_LSB   = 9;   // [10:9]
  localparam int A2_LSB   = 7;   // [8:7]
  localparam int A3_LSB   = 5;   // [6:5]
  localparam int TGT_LSB  = 1;   // [4:1], low PC_W bits used

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH x 16 words, synchronous write, synchronous registered read.
// Latency: write visible to a read on the following edge; read data one cycle after i_re.
// Backpressure: none; the caller gates i_we/i_re. Ports: i_clk, i_rst (clears read reg
// only), i_we/i_waddr/i_wdata write port, i_re/i_raddr read port, o_rdata registered word.
module seq_prog_mem
  import datapath_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Contents deliberately survive reset so a program can be rerun after an abort.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register doubles as the sequencer's instruction register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Microprogram sequencer driving the ALU/register-file datapath, branching on Zero.
// Latency: start at edge N -> FETCH in N+1, EXEC in N+2; two cycles per instruction.
// Backpressure: prog_we/start honoured only in IDLE, silently dropped while busy.
// Ports: clk/rst; prog_we/prog_addr/prog_wdata program load; start run request;
// Zero from datapath; wr/ALUControl/addr1-3 to datapath; busy/done/err status; pc debug.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int  PROG_DEPTH = 16,
  parameter int  MAX_STEPS  = 64,
  localparam int PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               start,
  input  logic               Zero,
  output logic               wr,
  output logic [2:0]         ALUControl,
  output logic [1:0]         addr1,
  output logic [1:0]         addr2,
  output logic [1:0]         addr3,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PC_W-1:0]    pc
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [STEP_W-1:0]  r_step;
  logic               r_err;
  logic [INSTR_W-1:0] w_ir;
  instr_type_e        w_type;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_target;
  logic               w_limit;
  logic               w_mem_we;
  logic               w_mem_re;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_mem_we = (r_state == S_IDLE) && prog_we && !rst;
  assign w_mem_re = (r_state == S_FETCH);

  seq_prog_mem #(.DEPTH(PROG_DEPTH)) u_prog_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_wdata),
    .i_re    (w_mem_re),
    .i_raddr (r_pc),
    .o_rdata (w_ir)
  );

  assign w_type   = instr_type_e'(w_ir[TYPE_LSB +: 2]);
  assign w_target = w_ir[TGT_LSB +: PC_W];
  assign w_pc_inc = r_pc + PC_W'(1);  // wraps modulo PROG_DEPTH
  // True on the EXEC that would be the MAX_STEPS-th executed instruction.
  assign w_limit  = (r_step + STEP_W'(1)) == STEP_W'(MAX_STEPS);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; HALT wins over the step limit so a clean halt never flags err.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = (w_type == T_HALT || w_limit) ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC, step counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_step <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_pc   <= '0;
      r_step <= '0;
      r_err  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_step <= r_step + STEP_W'(1);
      r_err  <= w_limit && (w_type != T_HALT);
      case (w_type)
        T_OP:    r_pc <= w_pc_inc;
        T_BRZ:   r_pc <= Zero ? w_target : w_pc_inc;
        T_JMP:   r_pc <= w_target;
        default: r_pc <= r_pc;  // HALT leaves pc on the HALT word
      endcase
    end
  end

  // Output decode; datapath controls are zero outside EXEC.
  always_comb begin
    wr         = 1'b0;
    ALUControl = 3'b000;
    addr1      = 2'b00;
    addr2      = 2'b00;
    addr3      = 2'b00;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    if (r_state == S_EXEC && (w_type == T_OP || w_type == T_BRZ)) begin
      ALUControl = w_ir[ALU_LSB +: 3];
      addr1      = w_ir[A1_LSB +: 2];
      addr2      = w_ir[A2_LSB +: 2];
      if (w_type == T_OP) begin
        wr    = 1'b1;
        addr3 = w_ir[A3_LSB +: 2];
      end
    end
  end

  assign err = r_err;
  assign pc  = r_pc;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: table-driven main run plus
// hand-written sequences for branch, step limit, busy-ignore, load+start and reset.
module tb_datapath_sequencer;
  import datapath_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        start;
  logic        Zero;
  logic        wr;
  logic [2:0]  ALUControl;
  logic [1:0]  addr1, addr2, addr3;
  logic        busy, done, err;
  logic [3:0]  pc;

  int n_chk = 0;
  int n_err = 0;

  datapath_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .Zero(Zero), .wr(wr),
    .ALUControl(ALUControl), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .busy(busy), .done(done), .err(err), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        zero;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [15:0] enc(input logic [1:0] t, input logic [2:0] alu,
                                      input logic [1:0] a1, input logic [1:0] a2,
                                      input logic [1:0] a3, input logic [3:0] tgt);
    return {t, alu, a1, a2, a3, tgt, 1'b0};
  endfunction

  // Packed view: {wr, alu, a1, a2, a3, busy, done, err, pc}
  function automatic logic [16:0] mk(input logic w, input logic [2:0] alu,
                                     input logic [1:0] a1, input logic [1:0] a2,
                                     input logic [1:0] a3, input logic b, input logic d,
                                     input logic e, input logic [3:0] p);
    return {w, alu, a1, a2, a3, b, d, e, p};
  endfunction

  function automatic logic [16:0] obs();
    return {wr, ALUControl, addr1, addr2, addr3, busy, done, err, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Waits (bounded) for done, then steps into IDLE.
  task automatic wait_done(input string name);
    int cnt = 0;
    while (!done && cnt < 300) begin
      tick();
      cnt++;
    end
    chk(name, {31'd0, done}, 32'd1);
    tick();
  endtask

  // Runs the main program from the table; noise holds prog_we/start high while busy.
  task automatic run_table(input string name, input bit noise);
    for (int i = 0; i < 8; i++) begin
      start      = tbl[i].start | (noise && i >= 1 && i <= 6);
      prog_we    = noise && i >= 1 && i <= 6;
      prog_addr  = 4'd0;
      prog_wdata = enc(T_HALT, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0);
      Zero       = tbl[i].zero;
      tick();
      chk($sformatf("%s[%0d]", name, i), {15'd0, obs()}, {15'd0, tbl[i].exp});
    end
    start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic load_main();
    load(4'd0, enc(T_OP, ALU_ADD, 2'd1, 2'd2, 2'd3, 4'd0));
    load(4'd1, enc(T_OP, ALU_XOR, 2'd0, 2'd0, 2'd1, 4'd0));
    load(4'd2, enc(T_HALT, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0));
  endtask

  initial begin
    int  cnt;
    bit  bad;

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; start = 1'b0; Zero = 1'b0;

    // Main program timeline: start at edge N, each entry is the cycle after its edge
    tbl[0] = '{1'b1, 1'b0, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 4'd0)};  // N+1 FETCH
    tbl[1] = '{1'b0, 1'b0, mk(1, 3'd0, 1, 2, 3, 1, 0, 0, 4'd0)};  // N+2 EXEC add
    tbl[2] = '{1'b0, 1'b0, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 4'd1)};  // N+3 FETCH
    tbl[3] = '{1'b0, 1'b0, mk(1, 3'd3, 0, 0, 1, 1, 0, 0, 4'd1)};  // N+4 EXEC xor
    tbl[4] = '{1'b0, 1'b0, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 4'd2)};  // N+5 FETCH
    tbl[5] = '{1'b0, 1'b0, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 4'd2)};  // N+6 EXEC HALT
    tbl[6] = '{1'b0, 1'b0, mk(0, 3'd0, 0, 0, 0, 1, 1, 0, 4'd2)};  // N+7 DONE
    tbl[7] = '{1'b0, 1'b0, mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 4'd2)};  // N+8 IDLE

    // Reset, with start pulsed while rst is high
    tick(); start = 1'b1; tick(); tick();
    chk("reset_outputs", {15'd0, obs()}, 32'd0);
    start = 1'b0; rst = 1'b0;
    tick();
    chk("reset_no_busy", {31'd0, busy}, 32'd0);

    // Main program
    load_main();
    run_table("main", 1'b0);

    // BRZ at address 0, target 5
    load(4'd0, enc(T_BRZ, ALU_SUB, 2'd1, 2'd2, 2'd0, 4'd5));
    load(4'd1, enc(T_HALT, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0));
    load(4'd5, enc(T_HALT, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0));
    Zero = 1'b1; start = 1'b1; tick(); start = 1'b0; tick();
    chk("brz_exec", {15'd0, obs()}, {15'd0, mk(0, 3'd1, 1, 2, 0, 1, 0, 0, 4'd0)});
    tick();
    chk("brz_taken_pc", {28'd0, pc}, 32'd5);
    wait_done("brz_taken_done");
    Zero = 1'b0; start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("brz_fall_pc", {28'd0, pc}, 32'd1);
    wait_done("brz_fall_done");

    // Runaway JMP 0 loop hits the step limit
    load(4'd0, enc(T_JMP, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0));
    start = 1'b1; tick(); start = 1'b0;
    cnt = 1; bad = 1'b0;
    while (!done && cnt < 300) begin
      if (wr) bad = 1'b1;
      tick();
      cnt++;
    end
    chk("jmp_done_cycle", cnt, 32'd129);
    chk("jmp_err_at_done", {31'd0, err}, 32'd1);
    chk("jmp_no_wr", {31'd0, bad}, 32'd0);
    tick();
    chk("jmp_err_held", {30'd0, busy, err}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("jmp_err_cleared", {30'd0, busy, err}, 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;

    // prog_we/start while busy are ignored; a clean rerun reads the program back
    load_main();
    run_table("busy_noise", 1'b1);
    run_table("readback", 1'b0);

    // Write together with start at address 0: the new word runs first
    prog_we = 1'b1; prog_addr = 4'd0;
    prog_wdata = enc(T_OP, ALU_AND, 2'd2, 2'd3, 2'd2, 4'd0);
    start = 1'b1; tick(); start = 1'b0; prog_we = 1'b0; tick();
    chk("we_start_exec", {15'd0, obs()}, {15'd0, mk(1, 3'd2, 2, 3, 2, 1, 0, 0, 4'd0)});
    wait_done("we_start_done");
    load(4'd0, enc(T_OP, ALU_ADD, 2'd1, 2'd2, 2'd3, 4'd0));

    // Reset during EXEC of an OP
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("rst_pre_wr", {31'd0, wr}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_outputs", {15'd0, obs()}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr || done || busy) bad = 1'b1;
    end
    chk("rst_quiet", {31'd0, bad}, 32'd0);
    run_table("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Microprogram sequencer for the 32-bit ALU/register-file `Datapath`. It holds a small loadable program of datapath micro-ops and executes it on `start`. Each step drives `wr`, `ALUControl`, `addr1`, `addr2` and `addr3` for one cycle, and it branches on the datapath `Zero` flag. It sits between the host/testbench and `Datapath`; `Datapath` itself is unchanged.

## Interface
- `PROG_DEPTH`, 16: number of program words, a power of 2; `PC_W = $clog2(PROG_DEPTH)`.
- `MAX_STEPS`, 64: runaway guard, the maximum number of executed instructions per run.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in PC_W: program write address.
- `prog_wdata` in 16: instruction word.
- `start` in 1: run request; honoured only in IDLE.
- `Zero` in 1: from `Datapath.Zero`.
- `wr` out 1: to `Datapath.wr`.
- `ALUControl` out 3: to `Datapath.ALUControl`.
- `addr1`, `addr2`, `addr3` out 2 each: to `Datapath`.
- `busy` out 1: high from the cycle after an accepted `start` until DONE is exited.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: set when the run ended on the step limit; held until the next accepted `start` or `rst`.
- `pc` out PC_W: current program counter, for debug.

## Operation
- Instruction word, 16 bits: [15:14] type, [13:11] alu, [10:9] a1, [8:7] a2, [6:5] a3, [4:1] target (low PC_W bits used), [0] reserved (0).
- Types:
  - 00 OP: `wr=1`, ALU op `alu`, write `a3`.
  - 01 BRZ: `wr=0`, ALU op `alu` on a1/a2; if `Zero`, `pc<=target`, else `pc+1`.
  - 10 HALT.
  - 11 JMP: `pc<=target`, `wr=0`.
- ALU codes pass through unchanged: 000 add, 001 sub, 010 and, 011 xor, 101 slt. Other codes are legal and produce a datapath result of 0.
- FSM states and transitions:
  - IDLE → FETCH on `start`.
  - FETCH: read `mem[pc]` into IR, then → EXEC.
  - EXEC: drive the datapath from IR and update `pc`/`step`. HALT → DONE. `step+1==MAX_STEPS` → DONE with `err=1`. Otherwise → FETCH.
  - DONE: `done=1`, then → IDLE.
- Accepted `start`: `pc<=0`, `step<=0`, `err<=0`.
- PC arithmetic is modulo PROG_DEPTH; `pc+1` from the last address wraps to 0.
- Datapath outputs `wr`, `ALUControl` and `addrN` are decoded from IR and forced to 0 in every state except EXEC. `wr` is never high outside EXEC.
- `prog_we` together with `start` in IDLE: the write commits at that edge, and FETCH sees the new word.
- `prog_we` or `start` while busy: ignored, with no side effects.
- Program memory is not cleared by `rst`. All other state is cleared.
- `rst` mid-run: next state is IDLE. No further `wr`, and no `done`.

## Timing
- Reset values: `wr=0`, `ALUControl=0`, `addr1`/`addr2`/`addr3=0`, `busy=0`, `done=0`, `err=0`, `pc=0`, state IDLE.
- `start` sampled high in IDLE at edge N: FETCH in cycle N+1 (`busy=1`), EXEC in N+2.
- Each instruction takes 2 cycles (FETCH + EXEC).
- A register write lands at the edge that ends EXEC.
- `Zero` is sampled combinationally in the EXEC cycle of a BRZ.
- A program of k instructions ending in HALT: `done` pulses in cycle N+2k+1, and `busy` falls the cycle after that.

## Structure
- Package `datapath_seq_pkg` holds:
  - the type codes (OP/BRZ/HALT/JMP);
  - the ALU code constants;
  - the state enum (IDLE/FETCH/EXEC/DONE);
  - the instruction field offsets.
- One sub-module, `seq_prog_mem`: PROG_DEPTH×16 synchronous-write, synchronous-read memory.
- Top module: FSM, PC, step counter, IR and output decode. The integration wrapper instantiates `datapath_sequencer` plus `Datapath`.

## Test plan
- Reset then idle: all outputs 0. Pulsing `start` with `rst` high produces no `busy`.
- Load {OP add a1=1 a2=2 a3=3; OP xor a1=0 a2=0 a3=1; HALT}, then start:
  - `wr=1` with ALUControl=000 and addr3=3 in N+2;
  - `wr=1` with ALUControl=011 and addr3=1 in N+4;
  - `done` in N+7, `err=0`;
  - `wr=0` in every other cycle.
- BRZ at address 0 with target=5: bench drives `Zero=1` → next FETCH `pc=5`; bench drives `Zero=0` → `pc=1`.
- Program `JMP 0` only, MAX_STEPS=64: `done` and `err=1` after 64 EXECs (`done` in N+129). The next `start` clears `err`.
- `prog_we` and `start` pulsed mid-run: program memory is unchanged, verified by readback run, and PC flow is unaffected. Separately, `prog_we` with `start` at `prog_addr=0` in IDLE: the new word executes first.
- `rst` asserted during EXEC of an OP: next cycle IDLE, `wr=0`, no `done`. The program is retained and reruns correctly.
